mod_inverse_seq: RTL and testbench

//  Sequential, parametrised modular-inverse engine: d = e^-1 mod phi via extended Euclid.

---
 rtl/rsa_pkg.sv | 19 +
 rtl/seq_div_step.sv | 27 ++
 rtl/mod_inverse_seq.sv | 141 ++++++++++++++
 tb/tb_mod_inverse_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the modular-inverse engine: FSM state encoding, default width
// and the signed (WIDTH+1)-bit coefficient type used for Bezout coefficients.
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIV,
    UPDATE,
    FIX,
    DONE
  } state_t;

  // Bezout coefficients satisfy |t| <= phi, so one extra sign bit suffices.
  typedef logic signed [DEFAULT_WIDTH:0] coef_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division bit (remainder shift/compare/subtract) plus the matching
// Horner-form update of the quotient-times-coefficient accumulator.
module seq_div_step #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH:0]   mult,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit,
  output logic [WIDTH:0]   acc_next
);

  logic [WIDTH:0] trial;

  always_comb begin
    trial    = {rem, dvd_bit};
    q_bit    = (trial >= {1'b0, divisor});
    // trial < 2*divisor, so the difference always fits in WIDTH bits.
    rem_next = q_bit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
    // acc tracks -(quotient so far)*mult; doubling per bit equals subtracting mult<<i.
    acc_next = q_bit ? ((acc << 1) - mult) : (acc << 1);
  end

endmodule

// File: rtl/mod_inverse_seq.sv
// Sequential modular inverse d = e^-1 mod phi by extended Euclid, one division bit per clock.
// Optional MODINV_GCD_OUT_EN adds a gcd output holding the final remainder.
module mod_inverse_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] phi,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] d,
`ifdef MODINV_GCD_OUT_EN
  output logic [WIDTH-1:0] gcd,
`endif
  output state_t           dbg_state
);

  // Handshake: start is sampled only in IDLE; busy covers CHECK..FIX; done pulses one cycle.
  localparam int CW = $clog2(WIDTH);

  state_t                  state;
  logic [WIDTH-1:0]        r, nr, rem, phi_q;
  logic signed [WIDTH:0]   t, nt, acc;
  logic [CW-1:0]           cnt;

  logic [WIDTH-1:0]        rem_next;
  logic                    q_bit;
  logic [WIDTH:0]          acc_next;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_bit  (r[WIDTH-1]),
    .divisor  (nr),
    .acc      (acc),
    .mult     (nt),
    .rem_next (rem_next),
    .q_bit    (q_bit),
    .acc_next (acc_next)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      d     <= '0;
      r     <= '0;
      nr    <= '0;
      rem   <= '0;
      phi_q <= '0;
      t     <= '0;
      nt    <= '0;
      acc   <= '0;
      cnt   <= '0;
`ifdef MODINV_GCD_OUT_EN
      gcd   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r     <= phi;
            nr    <= e;
            phi_q <= phi;
            t     <= '0;
            nt    <= (WIDTH+1)'(1);
            busy  <= 1'b1;
            err   <= 1'b0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (r < WIDTH'(2) || nr == '0) begin
            err   <= 1'b1;
            d     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef MODINV_GCD_OUT_EN
            gcd   <= r;
`endif
            state <= DONE;
          end else begin
            rem   <= '0;
            acc   <= '0;
            cnt   <= CW'(WIDTH - 1);
            state <= DIV;
          end
        end
        DIV: begin
          // r is consumed MSB first; its low bits fill with the (unused) quotient.
          r   <= {r[WIDTH-2:0], q_bit};
          rem <= rem_next;
          acc <= acc_next;
          if (cnt == '0) state <= UPDATE;
          else cnt <= cnt - CW'(1);
        end
        UPDATE: begin
          t   <= nt;
          nt  <= t + acc;
          r   <= nr;
          nr  <= rem;
          rem <= '0;
          acc <= '0;
          cnt <= CW'(WIDTH - 1);
          if (rem == '0) state <= FIX;
          else state <= DIV;
        end
        FIX: begin
          if (r != WIDTH'(1)) begin
            err <= 1'b1;
            d   <= '0;
          end else if (t < 0) begin
            d <= t[WIDTH-1:0] + phi_q;
          end else begin
            d <= t[WIDTH-1:0];
          end
`ifdef MODINV_GCD_OUT_EN
          gcd   <= r;
`endif
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse_seq.sv
// Self-checking bench for mod_inverse_seq at WIDTH=16 (table + corner sequences)
// and WIDTH=128 (e=65537 against a golden extended-Euclid model).
module tb_mod_inverse_seq;
  import rsa_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic         start16, busy16, done16, err16;
  logic [15:0]  e16, phi16, d16;
  state_t       dbg16;
  logic         start128, busy128, done128, err128;
  logic [127:0] e128, phi128, d128;
  state_t       dbg128;
`ifdef MODINV_GCD_OUT_EN
  logic [15:0]  gcd16;
  logic [127:0] gcd128;
`endif

  mod_inverse_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .e(e16), .phi(phi16),
    .busy(busy16), .done(done16), .err(err16), .d(d16),
`ifdef MODINV_GCD_OUT_EN
    .gcd(gcd16),
`endif
    .dbg_state(dbg16)
  );

  mod_inverse_seq #(.WIDTH(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start128), .e(e128), .phi(phi128),
    .busy(busy128), .done(done128), .err(err128), .d(d128),
`ifdef MODINV_GCD_OUT_EN
    .gcd(gcd128),
`endif
    .dbg_state(dbg128)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic         err;
    logic [127:0] d;
    logic [127:0] g;
    logic [127:0] e;
    logic [127:0] phi;
    int           lat;
    int           acc_cyc;
  } exp_t;

  typedef struct {
    logic [15:0] e;
    logic [15:0] phi;
    logic        err;
    logic [15:0] d;
    logic [15:0] g;
    int          lat;
  } vec_t;

  exp_t q16[$];
  exp_t q128[$];
  exp_t m16, m128;
  vec_t tbl[12];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void golden(input logic [127:0] ev, input logic [127:0] pv,
                                 output logic xerr, output logic [127:0] xd,
                                 output logic [127:0] xg);
    logic [127:0] r, nr, q, tmp;
    logic [129:0] t, nt, tt;
    if (pv < 128'd2 || ev == '0) begin
      xerr = 1'b1; xd = '0; xg = pv;
      return;
    end
    r = pv; nr = ev; t = '0; nt = 130'd1;
    while (nr != '0) begin
      q   = r / nr;
      tmp = r % nr;
      r   = nr;
      nr  = tmp;
      tt  = t - 130'(q) * nt;
      t   = nt;
      nt  = tt;
    end
    xg   = r;
    xerr = (r != 128'd1);
    xd   = xerr ? '0 : (t[129] ? 128'(t + 130'(pv)) : t[127:0]);
  endfunction

  // Output monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_done16: got done=1 expected none (t=%0t)", $time);
      end else begin
        m16 = q16.pop_front();
        check("err16", 128'(err16), 128'(m16.err));
        check("d16", 128'(d16), m16.d);
        check("busy_at_done16", 128'(busy16), 128'(0));
`ifdef MODINV_GCD_OUT_EN
        check("gcd16", 128'(gcd16), m16.g);
`endif
        if (m16.lat > 0) check("latency16", 128'(cyc - m16.acc_cyc), 128'(m16.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done128 === 1'b1) begin
      if (q128.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_done128: got done=1 expected none (t=%0t)", $time);
      end else begin
        m128 = q128.pop_front();
        check("err128", 128'(err128), 128'(m128.err));
        check("d128", d128, m128.d);
`ifdef MODINV_GCD_OUT_EN
        check("gcd128", gcd128, m128.g);
`endif
        if (!m128.err)
          check("d_times_e_mod_phi128",
                128'((256'(d128) * 256'(m128.e)) % 256'(m128.phi)), 128'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run16(input logic [15:0] ev, input logic [15:0] pv, input logic xerr,
                       input logic [15:0] xd, input logic [15:0] xg, input int lat);
    exp_t x;
    int   n;
    @(negedge clk);
    e16 = ev; phi16 = pv; start16 = 1'b1;
    x.err = xerr; x.d = 128'(xd); x.g = 128'(xg); x.e = 128'(ev); x.phi = 128'(pv);
    x.lat = lat; x.acc_cyc = cyc + 1;
    q16.push_back(x);
    @(negedge clk);
    start16 = 1'b0;
    e16 = 16'($urandom); phi16 = 16'($urandom);
    check("busy_after_start16", 128'(busy16), 128'(1));
    n = 0;
    while (done16 !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_vec++; n_miss++;
      $display("FAIL timeout16: got no done expected done within 1000 cycles");
      q16.delete();
    end
    @(negedge clk);
  endtask

  task automatic run128(input logic [127:0] ev, input logic [127:0] pv, output logic ok);
    exp_t x;
    int   n;
    @(negedge clk);
    e128 = ev; phi128 = pv; start128 = 1'b1;
    golden(ev, pv, x.err, x.d, x.g);
    x.e = ev; x.phi = pv; x.lat = 0; x.acc_cyc = cyc + 1;
    q128.push_back(x);
    @(negedge clk);
    start128 = 1'b0;
    e128 = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (done128 !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 8000);
    if (!ok) begin
      n_vec++; n_miss++;
      $display("FAIL timeout128: got no done expected done within 8000 cycles");
      q128.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic ok;
    int   n;
    logic [127:0] pv;

    tbl[0]  = '{16'd17,    16'd3120,  1'b0, 16'd2753, 16'd1,    70};
    tbl[1]  = '{16'd3,     16'd20,    1'b0, 16'd7,    16'd1,    53};
    tbl[2]  = '{16'd4,     16'd20,    1'b1, 16'd0,    16'd4,    19};
    tbl[3]  = '{16'd1,     16'd3120,  1'b0, 16'd1,    16'd1,    19};
    tbl[4]  = '{16'd0,     16'd3120,  1'b1, 16'd0,    16'd3120, 1};
    tbl[5]  = '{16'd5,     16'd1,     1'b1, 16'd0,    16'd1,    1};
    tbl[6]  = '{16'd7,     16'd0,     1'b1, 16'd0,    16'd0,    1};
    tbl[7]  = '{16'd20,    16'd3,     1'b0, 16'd2,    16'd1,    70};
    tbl[8]  = '{16'd20,    16'd20,    1'b1, 16'd0,    16'd20,   19};
    tbl[9]  = '{16'd65535, 16'd65534, 1'b0, 16'd1,    16'd1,    53};
    tbl[10] = '{16'd3,     16'd65535, 1'b1, 16'd0,    16'd3,    19};
    tbl[11] = '{16'd2753,  16'd3120,  1'b0, 16'd17,   16'd1,    0};

    rst_n = 1'b0;
    start16 = 1'b0; e16 = '0; phi16 = '0;
    start128 = 1'b0; e128 = '0; phi128 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy16", 128'(busy16), 128'(0));
    check("rst_done16", 128'(done16), 128'(0));
    check("rst_err16", 128'(err16), 128'(0));
    check("rst_d16", 128'(d16), 128'(0));
    check("rst_state16", 128'(dbg16), 128'(IDLE));
    check("rst_busy128", 128'(busy128), 128'(0));
    check("rst_d128", d128, 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run16(tbl[i].e, tbl[i].phi, tbl[i].err, tbl[i].d, tbl[i].g, tbl[i].lat);

    // start held high with a changing e: one result, computed from the first e
    @(negedge clk);
    e16 = 16'd3; phi16 = 16'd20; start16 = 1'b1;
    m16.err = 1'b0; m16.d = 128'd7; m16.g = 128'd1; m16.e = 128'd3; m16.phi = 128'd20;
    m16.lat = 53; m16.acc_cyc = cyc + 1;
    q16.push_back(m16);
    n = 0;
    do begin
      @(negedge clk);
      e16 = 16'($urandom_range(0, 65535));
      phi16 = 16'($urandom_range(0, 65535));
      n++;
    end while (done16 !== 1'b1 && n < 1000);
    start16 = 1'b0;
    if (n >= 1000) begin
      n_vec++; n_miss++;
      $display("FAIL timeout_held16: got no done expected done within 1000 cycles");
      q16.delete();
    end
    repeat (80) @(negedge clk);

    // asynchronous reset in the middle of a division
    @(negedge clk);
    e16 = 16'd17; phi16 = 16'd3120; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_mid_div16", 128'(busy16), 128'(1));
    check("state_mid_div16", 128'(dbg16), 128'(DIV));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy16", 128'(busy16), 128'(0));
    check("async_rst_done16", 128'(done16), 128'(0));
    check("async_rst_err16", 128'(err16), 128'(0));
    check("async_rst_d16", 128'(d16), 128'(0));
    check("async_rst_state16", 128'(dbg16), 128'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort16", 128'(q16.size()), 128'(0));
    run16(16'd17, 16'd3120, 1'b0, 16'd2753, 16'd1, 70);

    // WIDTH=128 with e=65537
    run128(128'd65537, 128'd65537 * 128'd12345, ok);
    if (ok) run128(128'd65537, 128'd3, ok);
    for (int i = 0; i < 24 && ok; i++) begin
      pv = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
      run128(128'd65537, pv, ok);
    end

    repeat (5) @(negedge clk);
    check("leftover16", 128'(q16.size()), 128'(0));
    check("leftover128", 128'(q128.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
